// File: rtl/cms_trace_serializer_if.sv
// Stream handshake bundle for the wide trace input and the narrow beat output.
interface cms_trace_serializer_if #(
    parameter int WIDTH = 64
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cms_trace_serializer.sv
// Buffers wide trace items in a small FIFO and replays each one as a sequence of
// narrow beats, least-significant slice first, with tlast on the final beat only.
module cms_trace_serializer #(
    parameter int IN_WIDTH  = 1024,
    parameter int OUT_WIDTH = 64,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    cms_trace_serializer_if.slave      S_AXIS,
    cms_trace_serializer_if.master     M_AXIS,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int BEATS  = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
            $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_EMPTY   = 1'b0,
        ST_SENDING = 1'b1
    } state_t;

    // Each entry holds {tlast, tdata} of one complete item.
    logic [IN_WIDTH:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [BEAT_W-1:0]  r_beat;
    logic [LVL_W-1:0]   r_level;
    state_t             r_state;
    state_t             w_next_state;

    logic               w_s_ready;
    logic               w_push;
    logic               w_m_fire;
    logic               w_last_beat;
    logic               w_pop;
    logic [IN_WIDTH:0]  w_head;
    logic [OUT_WIDTH-1:0] w_beat_data;

    // Ready comes from registered occupancy only, so a full buffer never accepts
    // an item even when the head pops in the same cycle.
    assign w_s_ready   = (r_level != LVL_FULL);
    assign w_push      = S_AXIS.tvalid && w_s_ready;
    assign w_m_fire    = (r_state == ST_SENDING) && M_AXIS.tready;
    assign w_last_beat = (r_beat == BEAT_LAST);
    assign w_pop       = w_m_fire && w_last_beat;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_beat_data = w_head[OUT_WIDTH*r_beat +: OUT_WIDTH];

    assign S_AXIS.tready = w_s_ready;
    assign level         = r_level;

    // Item storage write port.
    // NOTE: the data array carries no reset; its contents are only observed once level marks them valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {S_AXIS.tlast, S_AXIS.tdata};
        end
    end

    // Pointer, beat and occupancy bookkeeping; flush overrides any push or pop in the same cycle.
    // NOTE: non-blocking assignments make every register here sample the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_beat   <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_beat   <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_m_fire) begin
                r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_ONE;
            end
        end
    end

    // State register for the EMPTY/SENDING view of the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and beat outputs; tdata is forced to zero while nothing is buffered.
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        w_next_state  = r_state;
        M_AXIS.tvalid = 1'b0;
        M_AXIS.tdata  = '0;
        M_AXIS.tlast  = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_next_state = ST_SENDING;
                    end
                end
                ST_SENDING: begin
                    if (w_pop && !w_push && r_level == LVL_ONE) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
        if (r_state == ST_SENDING) begin
            M_AXIS.tvalid = 1'b1;
            M_AXIS.tdata  = w_beat_data;
            M_AXIS.tlast  = w_last_beat && w_head[IN_WIDTH];
        end
    end
endmodule

// File: tb/tb_cms_trace_serializer.sv
// Directed bench for cms_trace_serializer: inputs change and outputs are sampled on
// the falling edge, so every handshake happens on the following rising edge.
module tb_cms_trace_serializer;
    localparam int IN_WIDTH  = 1024;
    localparam int OUT_WIDTH = 64;
    localparam int DEPTH     = 4;
    localparam int BEATS     = IN_WIDTH / OUT_WIDTH;
    localparam int LVL_W     = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [LVL_W-1:0] level;
    int               n_cmp = 0;
    int               n_err = 0;

    cms_trace_serializer_if #(.WIDTH(IN_WIDTH))  s_if ();
    cms_trace_serializer_if #(.WIDTH(OUT_WIDTH)) m_if ();

    cms_trace_serializer #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .S_AXIS(s_if),
        .M_AXIS(m_if),
        .flush (flush),
        .level (level)
    );

    always #5 clk = ~clk;

    // Item whose 64-bit slice k holds base + k.
    function automatic logic [IN_WIDTH-1:0] mk_item(input int base);
        logic [IN_WIDTH-1:0] it;
        it = '0;
        for (int k = 0; k < BEATS; k++) it[OUT_WIDTH*k +: OUT_WIDTH] = 64'(base + k);
        return it;
    endfunction

    task automatic offer(input int base, input logic last);
        s_if.tdata  = mk_item(base);
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL reset_s_tready: got %b want 1", s_if.tready); end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid: got %b want 0", m_if.tvalid); end
        n_cmp++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL reset_m_tlast: got %b want 0", m_if.tlast); end
        n_cmp++; if (m_if.tdata !== 64'h0) begin n_err++; $display("FAIL reset_m_tdata: got %h want 0", m_if.tdata); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        offer(0, 1'b1);
        m_if.tready = 1'b1;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL single_pre_tvalid: got %b want 0", m_if.tvalid); end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", level); end
        for (int k = 0; k < BEATS; k++) begin
            n_cmp++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL single_tvalid[%0d]: got %b want 1", k, m_if.tvalid); end
            n_cmp++; if (m_if.tdata !== 64'(k)) begin n_err++; $display("FAIL single_tdata[%0d]: got %h want %h", k, m_if.tdata, 64'(k)); end
            n_cmp++; if (m_if.tlast !== (k == BEATS - 1)) begin n_err++; $display("FAIL single_tlast[%0d]: got %b want %b", k, m_if.tlast, (k == BEATS - 1)); end
            @(negedge clk);
        end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL single_post_tvalid: got %b want 0", m_if.tvalid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL single_post_level: got %0d want 0", level); end
    endtask

    task automatic test_back_to_back();
        int          rx;
        bit          acc4;
        logic [63:0] exp_d;
        logic        exp_l;
        m_if.tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(256 * i, 1'(i % 2));
            n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL b2b_accept[%0d]: got %b want 1", i, s_if.tready); end
            @(negedge clk);
        end
        offer(1024, 1'b0);
        n_cmp++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b want 0", s_if.tready); end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL b2b_full_level: got %0d want 4", level); end
        m_if.tready = 1'b1;
        rx = 0;
        acc4 = 1'b0;
        for (int cyc = 0; cyc < 200 && rx < 5 * BEATS; cyc++) begin
            if (!acc4 && s_if.tready) begin
                n_cmp++; if (rx !== BEATS) begin n_err++; $display("FAIL b2b_fifth_accept: after %0d beats want %0d", rx, BEATS); end
                acc4 = 1'b1;
            end
            if (m_if.tvalid) begin
                exp_d = 64'(256 * (rx / BEATS) + rx % BEATS);
                exp_l = (rx % BEATS == BEATS - 1) && ((rx / BEATS) % 2 == 1);
                n_cmp++; if (m_if.tdata !== exp_d) begin n_err++; $display("FAIL b2b_tdata[%0d]: got %h want %h", rx, m_if.tdata, exp_d); end
                n_cmp++; if (m_if.tlast !== exp_l) begin n_err++; $display("FAIL b2b_tlast[%0d]: got %b want %b", rx, m_if.tlast, exp_l); end
                rx++;
            end
            @(negedge clk);
            if (acc4) s_if.tvalid = 1'b0;
        end
        s_if.tvalid = 1'b0;
        n_cmp++; if (rx !== 5 * BEATS) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", rx, 5 * BEATS); end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL b2b_post_tvalid: got %b want 0", m_if.tvalid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL b2b_post_level: got %0d want 0", level); end
    endtask

    task automatic test_stall();
        offer(32'h500, 1'b1);
        m_if.tready = 1'b0;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        for (int c = 0; c < 2 * BEATS; c++) begin
            m_if.tready = 1'(c % 2);
            n_cmp++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL stall_tvalid[%0d]: got %b want 1", c, m_if.tvalid); end
            n_cmp++; if (m_if.tdata !== 64'(32'h500 + c / 2)) begin n_err++; $display("FAIL stall_tdata[%0d]: got %h want %h", c, m_if.tdata, 64'(32'h500 + c / 2)); end
            n_cmp++; if (m_if.tlast !== (c / 2 == BEATS - 1)) begin n_err++; $display("FAIL stall_tlast[%0d]: got %b want %b", c, m_if.tlast, (c / 2 == BEATS - 1)); end
            @(negedge clk);
        end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL stall_post_tvalid: got %b want 0", m_if.tvalid); end
    endtask

    task automatic test_tlast_pair();
        logic [63:0] exp_d;
        m_if.tready = 1'b0;
        offer(32'h600, 1'b0);
        @(negedge clk);
        offer(32'h700, 1'b1);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        for (int rx = 0; rx < 2 * BEATS; rx++) begin
            exp_d = 64'(((rx < BEATS) ? 32'h600 : 32'h700) + rx % BEATS);
            n_cmp++; if (m_if.tdata !== exp_d) begin n_err++; $display("FAIL pair_tdata[%0d]: got %h want %h", rx, m_if.tdata, exp_d); end
            n_cmp++; if (m_if.tlast !== (rx == 2 * BEATS - 1)) begin n_err++; $display("FAIL pair_tlast[%0d]: got %b want %b", rx, m_if.tlast, (rx == 2 * BEATS - 1)); end
            @(negedge clk);
        end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL pair_post_tvalid: got %b want 0", m_if.tvalid); end
    endtask

    task automatic test_flush();
        m_if.tready = 1'b0;
        offer(32'h800, 1'b1);
        @(negedge clk);
        offer(32'h900, 1'b1);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (7) @(negedge clk);
        n_cmp++; if (m_if.tdata !== 64'h807) begin n_err++; $display("FAIL flush_pre_tdata: got %h want 807", m_if.tdata); end
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL flush_pre_level: got %0d want 2", level); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL flush_tvalid: got %b want 0", m_if.tvalid); end
        n_cmp++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL flush_tlast: got %b want 0", m_if.tlast); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL flush_s_tready: got %b want 1", s_if.tready); end
        offer(32'hA00, 1'b0);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL flush_c_level: got %0d want 1", level); end
        for (int k = 0; k < BEATS; k++) begin
            n_cmp++; if (m_if.tdata !== 64'(32'hA00 + k)) begin n_err++; $display("FAIL flush_c_tdata[%0d]: got %h want %h", k, m_if.tdata, 64'(32'hA00 + k)); end
            n_cmp++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL flush_c_tlast[%0d]: got %b want 0", k, m_if.tlast); end
            @(negedge clk);
        end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL flush_c_post_tvalid: got %b want 0", m_if.tvalid); end
    endtask

    task automatic test_async_reset();
        m_if.tready = 1'b1;
        offer(32'hB00, 1'b1);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (m_if.tdata !== 64'hB03) begin n_err++; $display("FAIL arst_pre_tdata: got %h want b03", m_if.tdata); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL arst_tvalid: got %b want 0", m_if.tvalid); end
        n_cmp++; if (m_if.tdata !== 64'h0) begin n_err++; $display("FAIL arst_tdata: got %h want 0", m_if.tdata); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL arst_level: got %0d want 0", level); end
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL arst_s_tready: got %b want 1", s_if.tready); end
        @(negedge clk);
        rst = 1'b0;
        offer(32'hC00, 1'b1);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        n_cmp++; if (m_if.tdata !== 64'hC00) begin n_err++; $display("FAIL arst_restart_tdata: got %h want c00", m_if.tdata); end
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL arst_restart_level: got %0d want 1", level); end
        repeat (BEATS) @(negedge clk);
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL arst_drain_tvalid: got %b want 0", m_if.tvalid); end
    endtask

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_tlast_pair();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
